// File: rtl/alu_opr_stage.sv
// Operand-select stage: decodes RV immediates, forwards rs1/rs2 and registers ALU operands behind a valid/ready handshake.
// Build option: define ALU_OPR_FWD_EN to compile in the forwarding network.
module alu_opr_stage #(
    parameter int XLEN  = 32,
    parameter int N_FWD = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             instr,
    input  logic [XLEN-1:0]         pc,
    input  logic [XLEN-1:0]         rdata1,
    input  logic [XLEN-1:0]         rdata2,
    input  logic [N_FWD-1:0]        fwd_valid,
    input  logic [5*N_FWD-1:0]      fwd_addr,
    input  logic [XLEN*N_FWD-1:0]   fwd_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         opr_a,
    output logic [XLEN-1:0]         opr_b,
    output logic [XLEN-1:0]         st_data,
    output logic                    out_illegal
);
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [6:0]      opcode;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_x;
    logic            imm_ok;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    logic [XLEN-1:0] opr_a_d, opr_b_d;
    logic            illegal_d;
    logic [XLEN-1:0] opr_a_q, opr_b_q, st_data_q;
    logic            illegal_q, out_valid_q;
    logic            capture;

    assign opcode   = instr[6:0];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    always_comb begin
        imm32  = 32'd0;
        imm_ok = 1'b1;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:                 imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:                imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_JAL:                   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            OP_LUI, OP_AUIPC:         imm32 = {instr[31:12], 12'd0};
            default:                  imm_ok = 1'b0;
        endcase
        imm_x       = {XLEN{imm32[31]}};
        imm_x[31:0] = imm32;
    end

`ifdef ALU_OPR_FWD_EN
    logic [N_FWD-1:0] hit1, hit2;
    logic [XLEN-1:0]  ch_data [N_FWD];

    // x0 is excluded so a stale producer targeting x0 can never override the constant zero.
    for (genvar gi = 0; gi < N_FWD; gi++) begin : g_fwd
        assign ch_data[gi] = fwd_data[XLEN*gi +: XLEN];
        assign hit1[gi]    = fwd_valid[gi] && (fwd_addr[5*gi +: 5] == rs1_addr) && (rs1_addr != 5'd0);
        assign hit2[gi]    = fwd_valid[gi] && (fwd_addr[5*gi +: 5] == rs2_addr) && (rs2_addr != 5'd0);
    end

    // Walk from the top channel down so the lowest-indexed hit wins.
    always_comb begin
        rs1_val = rdata1;
        rs2_val = rdata2;
        for (int i = N_FWD - 1; i >= 0; i--) begin
            if (hit1[i]) rs1_val = ch_data[i];
            if (hit2[i]) rs2_val = ch_data[i];
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_valid, fwd_addr, fwd_data};
    assign rs1_val    = rdata1;
    assign rs2_val    = rdata2;
`endif

    always_comb begin
        opr_b_d   = imm_x;
        illegal_d = 1'b0;
        if (opcode == OP_REG) begin
            opr_b_d = rs2_val;
        end else if (!imm_ok) begin
            opr_b_d   = '0;
            illegal_d = 1'b1;
        end
        case (opcode)
            OP_AUIPC, OP_JAL, OP_BRANCH: opr_a_d = pc;
            OP_LUI:                      opr_a_d = '0;
            default:                     opr_a_d = rs1_val;
        endcase
    end

    assign in_ready = (!out_valid_q || out_ready) && !flush && !rst;
    assign capture  = in_valid && in_ready;

    // Flush kills the valid bit only; data registers keep their last contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            opr_a_q     <= '0;
            opr_b_q     <= '0;
            st_data_q   <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            illegal_q   <= illegal_d;
            opr_a_q     <= opr_a_d;
            opr_b_q     <= opr_b_d;
            st_data_q   <= rs2_val;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_illegal = illegal_q;
    assign opr_a       = opr_a_q;
    assign opr_b       = opr_b_q;
    assign st_data     = st_data_q;
endmodule

// File: tb/tb_alu_opr_stage.sv
// Directed bench for alu_opr_stage: vector table for decode/forwarding plus hand sequences for stall, flush and reset.
module tb_alu_opr_stage;
`ifdef ALU_OPR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [31:0] instr, pc, rdata1, rdata2;
    logic [1:0]  fwd_valid;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] opr_a, opr_b, st_data;

    logic         in_ready64, out_valid64, out_illegal64;
    logic [63:0]  opr_a64, opr_b64, st_data64;
    logic [127:0] fwd_data64;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign fwd_data64 = {32'd0, fwd_data[63:32], 32'd0, fwd_data[31:0]};

    alu_opr_stage #(.XLEN(32), .N_FWD(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rdata1(rdata1), .rdata2(rdata2),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .opr_a(opr_a), .opr_b(opr_b), .st_data(st_data), .out_illegal(out_illegal)
    );

    alu_opr_stage #(.XLEN(64), .N_FWD(2)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .pc({32'd0, pc}), .rdata1({32'd0, rdata1}), .rdata2({32'd0, rdata2}),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data64),
        .flush(flush), .out_valid(out_valid64), .out_ready(out_ready),
        .opr_a(opr_a64), .opr_b(opr_b64), .st_data(st_data64), .out_illegal(out_illegal64)
    );

    typedef struct {
        logic [31:0] instr, pc, rd1, rd2;
        logic [1:0]  fv;
        logic [9:0]  fa;
        logic [63:0] fd;
        logic [31:0] ea, eb, est;
        logic        eill;
        logic        c64;
        logic [63:0] ea64, eb64;
    } vec_t;

    vec_t vecs [16];
    int   nv = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [31:0] i, p, r1, r2, input logic [1:0] fv, input logic [9:0] fa,
                       input logic [63:0] fd, input logic [31:0] ea, eb, est, input logic ill,
                       input logic c64, input logic [63:0] ea64, eb64);
        vecs[nv] = '{i, p, r1, r2, fv, fa, fd, ea, eb, est, ill, c64, ea64, eb64};
        nv++;
    endtask

    task automatic drive(input logic [31:0] i, p, r1, r2);
        instr = i; pc = p; rdata1 = r1; rdata2 = r2;
        fwd_valid = 2'b00; fwd_addr = '0; fwd_data = '0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0);

        // ADDI x1,x2,-5
        add(32'hFFB10093, 32'h100, 32'h7, 32'h55, 2'b00, 10'd0, 64'd0, 32'h7, 32'hFFFFFFFB, 32'h55, 1'b0, 1'b0, 0, 0);
        // ADD x5,x1,x3: both channels hit x3, channel 0 wins
        add(32'h003082B3, 32'h104, 32'hA, 32'h1, 2'b11, {5'd3, 5'd3}, {32'h22, 32'h11},
            32'hA, FWD ? 32'h11 : 32'h1, FWD ? 32'h11 : 32'h1, 1'b0, 1'b0, 0, 0);
        // only channel 1 valid
        add(32'h003082B3, 32'h108, 32'hA, 32'h1, 2'b10, {5'd3, 5'd3}, {32'h22, 32'h11},
            32'hA, FWD ? 32'h22 : 32'h1, FWD ? 32'h22 : 32'h1, 1'b0, 1'b0, 0, 0);
        // rs1 on channel 1, rs2 on channel 0
        add(32'h003082B3, 32'h10C, 32'hA, 32'h1, 2'b11, {5'd1, 5'd3}, {32'h33, 32'h11},
            FWD ? 32'h33 : 32'hA, FWD ? 32'h11 : 32'h1, FWD ? 32'h11 : 32'h1, 1'b0, 1'b0, 0, 0);
        // ADD x5,x1,x0 with fwd0 targeting x0: never forwarded
        add(32'h000082B3, 32'h110, 32'hA, 32'h7, 2'b01, {5'd0, 5'd0}, {32'h0, 32'h99},
            32'hA, 32'h7, 32'h7, 1'b0, 1'b0, 0, 0);
        // illegal opcode 0x7F
        add(32'h0000007F, 32'h114, 32'h3, 32'h9, 2'b00, 10'd0, 64'd0, 32'h3, 32'h0, 32'h9, 1'b1, 1'b0, 0, 0);
        // LUI x1,0x12345
        add(32'h123450B7, 32'h118, 32'h5, 32'h6, 2'b00, 10'd0, 64'd0, 32'h0, 32'h12345000, 32'h6, 1'b0,
            1'b1, 64'h0, 64'h0000000012345000);
        // LUI x1,0x80000: sign-extends on the 64-bit build
        add(32'h800000B7, 32'h11C, 32'h5, 32'h6, 2'b00, 10'd0, 64'd0, 32'h0, 32'h80000000, 32'h6, 1'b0,
            1'b1, 64'h0, 64'hFFFFFFFF80000000);
        // AUIPC x1,0x1
        add(32'h00001097, 32'h200, 32'h5, 32'h6, 2'b00, 10'd0, 64'd0, 32'h200, 32'h1000, 32'h6, 1'b0, 1'b0, 0, 0);
        // SW x3,-4(x1)
        add(32'hFE30AE23, 32'h204, 32'h1000, 32'hDEAD, 2'b00, 10'd0, 64'd0, 32'h1000, 32'hFFFFFFFC, 32'hDEAD, 1'b0, 1'b0, 0, 0);
        // BEQ x1,x2,-8
        add(32'hFE208CE3, 32'h300, 32'h1, 32'h2, 2'b00, 10'd0, 64'd0, 32'h300, 32'hFFFFFFF8, 32'h2, 1'b0, 1'b0, 0, 0);
        // JAL x1,+2048
        add(32'h001000EF, 32'h400, 32'h1, 32'h2, 2'b00, 10'd0, 64'd0, 32'h400, 32'h800, 32'h2, 1'b0, 1'b0, 0, 0);
        // JALR x1,16(x5)
        add(32'h010280E7, 32'h404, 32'h4000, 32'h2, 2'b00, 10'd0, 64'd0, 32'h4000, 32'h10, 32'h2, 1'b0, 1'b0, 0, 0);
        // LW x1,0x7FF(x2)
        add(32'h7FF12083, 32'h408, 32'h8, 32'h2, 2'b00, 10'd0, 64'd0, 32'h8, 32'h7FF, 32'h2, 1'b0, 1'b0, 0, 0);

        step(); step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_opr_a", opr_a, 0);
        chk("rst_opr_b", opr_b, 0);
        chk("rst_st_data", st_data, 0);
        chk("rst_illegal", out_illegal, 0);

        rst = 1'b0; out_ready = 1'b1; #1;
        chk("idle_in_ready", in_ready, 1);

        // One vector per cycle, consumer always ready.
        for (int k = 0; k < nv; k++) begin
            in_valid = 1'b1;
            instr = vecs[k].instr; pc = vecs[k].pc; rdata1 = vecs[k].rd1; rdata2 = vecs[k].rd2;
            fwd_valid = vecs[k].fv; fwd_addr = vecs[k].fa; fwd_data = vecs[k].fd;
            step();
            chk($sformatf("vec%0d_out_valid", k), out_valid, 1);
            chk($sformatf("vec%0d_opr_a", k), opr_a, vecs[k].ea);
            chk($sformatf("vec%0d_opr_b", k), opr_b, vecs[k].eb);
            chk($sformatf("vec%0d_st_data", k), st_data, vecs[k].est);
            chk($sformatf("vec%0d_illegal", k), out_illegal, vecs[k].eill);
            if (vecs[k].c64) begin
                chk($sformatf("vec%0d_opr_a64", k), opr_a64, vecs[k].ea64);
                chk($sformatf("vec%0d_opr_b64", k), opr_b64, vecs[k].eb64);
            end
        end

        // Drain with nothing new: out_valid drops next edge.
        in_valid = 1'b0;
        step();
        chk("drain_out_valid", out_valid, 0);

        // Stall: capture ADDI, then hold with out_ready=0 while a new bundle waits.
        in_valid = 1'b1; out_ready = 1'b0;
        drive(32'hFFB10093, 32'h500, 32'h7, 32'h55);
        step();
        chk("stall_cap_valid", out_valid, 1);
        drive(32'h123450B7, 32'h504, 32'h9, 32'h66);
        fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd2}; fwd_data = {32'h0, 32'hBAD};
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", c), in_ready, 0);
            step();
            chk($sformatf("stall%0d_out_valid", c), out_valid, 1);
            chk($sformatf("stall%0d_opr_a", c), opr_a, 32'h7);
            chk($sformatf("stall%0d_opr_b", c), opr_b, 32'hFFFFFFFB);
            chk($sformatf("stall%0d_st_data", c), st_data, 32'h55);
        end
        out_ready = 1'b1; #1;
        chk("unstall_in_ready", in_ready, 1);
        step();
        chk("unstall_out_valid", out_valid, 1);
        chk("unstall_opr_a", opr_a, 32'h0);
        chk("unstall_opr_b", opr_b, 32'h12345000);

        // Flush with valid output, new bundle and out_ready all asserted.
        drive(32'h0000007F, 32'h508, 32'h3, 32'h9);
        in_valid = 1'b1; flush = 1'b1; #1;
        chk("flush_in_ready", in_ready, 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_opr_b_kept", opr_b, 32'h12345000);
        chk("flush_illegal", out_illegal, 0);
        step();
        chk("flush_no_emit", out_valid, 0);

        // Reset arriving mid-stall.
        in_valid = 1'b1; out_ready = 1'b0;
        drive(32'hFE30AE23, 32'h600, 32'h1000, 32'hDEAD);
        step();
        in_valid = 1'b0;
        step();
        chk("prerst_out_valid", out_valid, 1);
        rst = 1'b1; #1;
        chk("rst_mid_in_ready", in_ready, 0);
        step();
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_opr_a", opr_a, 0);
        chk("rst_mid_opr_b", opr_b, 0);
        chk("rst_mid_st_data", st_data, 0);
        chk("rst_mid_illegal", out_illegal, 0);
        rst = 1'b0;
        step();
        chk("postrst_out_valid", out_valid, 0);
        chk("postrst_opr_a", opr_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
